// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register array with one bit-masked write port and two
// combinational read ports, optional same-cycle write forwarding, and a written bitmap.
module reg_bank #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [DEPTH-1:0] written
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic [DEPTH-1:0] written_d;

  logic             wr_en_s;
  logic [WIDTH-1:0] stored_w_s;
  logic [WIDTH-1:0] stored_a_s;
  logic [WIDTH-1:0] stored_b_s;
  logic [WIDTH-1:0] merged_s;

  // Out-of-range addresses never match a register, so they neither write nor read.
  assign wr_en_s = we & ~reset & ({1'b0, waddr} < DEPTH_C);

  // Address decode: at most one register matches, so OR-ing the selected words is a mux.
  always_comb begin
    stored_w_s = {WIDTH{1'b0}};
    stored_a_s = {WIDTH{1'b0}};
    stored_b_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      stored_w_s = stored_w_s | ((waddr   == AW'(i)) ? mem_q[i] : {WIDTH{1'b0}});
      stored_a_s = stored_a_s | ((raddr_a == AW'(i)) ? mem_q[i] : {WIDTH{1'b0}});
      stored_b_s = stored_b_s | ((raddr_b == AW'(i)) ? mem_q[i] : {WIDTH{1'b0}});
    end
    merged_s = (stored_w_s & ~wmask) | (wdata & wmask);
  end

  // Next-state for the array and the sticky written bitmap.
  always_comb begin
    written_d = written_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en_s && (waddr == AW'(i))) begin
        mem_d[i]     = merged_s;
        written_d[i] = 1'b1;
      end else begin
        mem_d[i]     = mem_q[i];
        written_d[i] = written_q[i];
      end
    end
  end

  // Read ports forward the merged write value when bypass is enabled and the addresses meet.
  always_comb begin
    if ((BYPASS != 0) && wr_en_s && (raddr_a == waddr)) begin
      rdata_a = merged_s;
    end else begin
      rdata_a = stored_a_s;
    end
    if ((BYPASS != 0) && wr_en_s && (raddr_b == waddr)) begin
      rdata_b = merged_s;
    end else begin
      rdata_b = stored_b_s;
    end
  end

  // State registers; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '{default: {WIDTH{1'b0}}};
      written_q <= {DEPTH{1'b0}};
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
    end
  end

  assign written = written_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a bypass build, a no-bypass build and a DEPTH=6 build
// share one stimulus stream; expectations are queued at drive time and popped at sample time.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] wmask;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;

  logic [15:0] rd_a_m, rd_b_m, rd_a_n, rd_b_n, rd_a_6, rd_b_6;
  logic [7:0]  wr_m, wr_n;
  logic [5:0]  wr_6;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_main (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(rd_a_m), .raddr_b(raddr_b), .rdata_b(rd_b_m), .written(wr_m)
  );

  reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(rd_a_n), .raddr_b(raddr_b), .rdata_b(rd_b_n), .written(wr_n)
  );

  reg_bank #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) u_d6 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(rd_a_6), .raddr_b(raddr_b), .rdata_b(rd_b_6), .written(wr_6)
  );

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic [15:0] m);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    wmask = m;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = 3'd0; wdata = 16'h0000; wmask = 16'h0000;
    raddr_a = 3'd0; raddr_b = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state on every address.
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a);
      raddr_b = 3'(7 - a);
      push("t1_rst_rd_a", 16'h0000);
      push("t1_rst_rd_b", 16'h0000);
      #1;
      check(rd_a_m);
      check(rd_b_m);
    end
    push("t1_written", 16'h0000);
    push("t1_written_d6", 16'h0000);
    check({8'h00, wr_m});
    check({10'h000, wr_6});

    // Full write, one-cycle latency.
    do_write(3'd3, 16'hBEEF, 16'hFFFF);
    raddr_a = 3'd3;
    push("t2_rd_a", 16'hBEEF);
    push("t2_rd_a_nb", 16'hBEEF);
    push("t2_written", 16'h0008);
    #1;
    check(rd_a_m);
    check(rd_a_n);
    check({8'h00, wr_m});

    // Masked write leaves neighbours alone.
    do_write(3'd2, 16'h5A5A, 16'hFFFF);
    do_write(3'd4, 16'hA5A5, 16'hFFFF);
    do_write(3'd3, 16'h1234, 16'h00FF);
    raddr_a = 3'd3;
    raddr_b = 3'd2;
    push("t3_masked", 16'hBE34);
    push("t3_reg2", 16'h5A5A);
    #1;
    check(rd_a_m);
    check(rd_b_m);
    raddr_b = 3'd4;
    push("t3_reg4", 16'hA5A5);
    #1;
    check(rd_b_m);

    // Same-cycle forwarding versus stored-only read.
    do_write(3'd5, 16'h7700, 16'hFFFF);
    we = 1'b1; waddr = 3'd5; wdata = 16'h00AA; wmask = 16'hFFFF; raddr_b = 3'd5;
    push("t4_bypass", 16'h00AA);
    push("t4_nb_old", 16'h7700);
    #1;
    check(rd_b_m);
    check(rd_b_n);
    @(posedge clk);
    #1 we = 1'b0;
    push("t4_nb_next", 16'h00AA);
    push("t4_main_next", 16'h00AA);
    #1;
    check(rd_b_n);
    check(rd_b_m);

    // Forwarding of a partially masked write merges with the stored word.
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234; wmask = 16'hFF00; raddr_a = 3'd5;
    push("t4_merge_byp", 16'h12AA);
    push("t4_merge_nb_old", 16'h00AA);
    #1;
    check(rd_a_m);
    check(rd_a_n);
    @(posedge clk);
    #1 we = 1'b0;
    push("t4_merge_nb_next", 16'h12AA);
    #1;
    check(rd_a_n);

    // Out-of-range address on the 6-deep build.
    we = 1'b1; waddr = 3'd7; wdata = 16'hFFFF; wmask = 16'hFFFF; raddr_a = 3'd7;
    push("t5_d6_no_fwd", 16'h0000);
    #1;
    check(rd_a_6);
    @(posedge clk);
    #1 we = 1'b0;
    raddr_b = 3'd6;
    push("t5_d6_rd7", 16'h0000);
    push("t5_d6_written", 16'h003C);
    push("t5_main_rd7", 16'hFFFF);
    push("t5_main_written", 16'h00BC);
    push("t5_d6_rd6", 16'h0000);
    #1;
    check(rd_a_6);
    check({10'h000, wr_6});
    check(rd_a_m);
    check({8'h00, wr_m});
    check(rd_b_6);

    // Zero-mask write still marks the register as written.
    do_write(3'd0, 16'hFFFF, 16'h0000);
    raddr_a = 3'd0;
    push("t5_mask0_rd", 16'h0000);
    push("t5_mask0_written", 16'h00BD);
    #1;
    check(rd_a_m);
    check({8'h00, wr_m});

    // Reset beats a same-cycle write and suppresses forwarding.
    reset = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'hFFFF; wmask = 16'hFFFF;
    raddr_a = 3'd1; raddr_b = 3'd3;
    push("t6_no_fwd", 16'h0000);
    push("t6_stored_b", 16'hBE34);
    #1;
    check(rd_a_m);
    check(rd_b_m);
    @(posedge clk);
    #1 reset = 1'b0; we = 1'b0;
    push("t6_reg1", 16'h0000);
    push("t6_reg3", 16'h0000);
    push("t6_written", 16'h0000);
    push("t6_written_d6", 16'h0000);
    #1;
    check(rd_a_m);
    check(rd_b_m);
    check({8'h00, wr_m});
    check({10'h000, wr_6});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
